bpu_update_scheduler: RTL



---
 rtl/bpu_update_scheduler.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/bpu_update_scheduler.sv
// Sole writer of the combined BTB/BHT table: drains resolved-branch updates from EXE and runs table flushes.
// Optional: define BPU_UPD_COALESCE_EN to merge an update into the FIFO tail entry when the pc matches.
module bpu_update_scheduler #(
  parameter int DEPTH       = 32,
  parameter int ADDR_WIDTH  = 64,
  parameter int QUEUE_DEPTH = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 upd_valid_i,
  output logic                                 upd_ready_o,
  input  logic [ADDR_WIDTH-1:0]                upd_pc_i,
  input  logic [ADDR_WIDTH-1:0]                upd_target_i,
  input  logic                                 upd_jump_i,
  input  logic                                 flush_req_i,
  output logic                                 flush_busy_o,
  output logic                                 flush_done_o,
  output logic                                 predict_disable_o,
  output logic                                 wr_en_o,
  output logic                                 wr_invalidate_o,
  output logic [$clog2(DEPTH)-1:0]             wr_index_o,
  output logic [ADDR_WIDTH-$clog2(DEPTH)-3:0]  wr_tag_o,
  output logic [ADDR_WIDTH-1:0]                wr_target_o,
  output logic                                 wr_jump_o,
  output logic [CNT_WIDTH-1:0]                 dropped_cnt_o
);
  localparam int IW = $clog2(DEPTH);
  localparam int TW = ADDR_WIDTH - IW - 2;
  localparam int QW = $clog2(QUEUE_DEPTH);
  localparam int WW = IW + 1;
  localparam int PW = QW + 1;
  localparam int SW = CNT_WIDTH + 1;
  localparam logic [WW-1:0] WALK_END = WW'(DEPTH);

  typedef enum logic {S_IDLE, S_FLUSH} state_e;

  state_e                state_q, state_d;
  logic [WW-1:0]         walk_q, walk_d;
  logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d, occ;
  logic [ADDR_WIDTH-1:0] mem_pc  [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] mem_tgt [QUEUE_DEPTH];
  logic                  mem_jmp [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] head_pc;

  logic                  wr_en_d, wr_inv_d, wr_jump_d, flush_done_d;
  logic [IW-1:0]         wr_index_d;
  logic [TW-1:0]         wr_tag_d;
  logic [ADDR_WIDTH-1:0] wr_target_d;
  logic [CNT_WIDTH-1:0]  dropped_d;
  logic [PW-1:0]         drop_inc;
  logic [SW-1:0]         drop_sum;
  logic                  empty, full, pop, push, accept, tail_hit, coalesce;

  assign occ     = wptr_q - rptr_q;
  assign empty   = (occ == '0);
  assign full    = (occ == PW'(QUEUE_DEPTH));
  assign head_pc = mem_pc[rptr_q[QW-1:0]];
  assign pop     = (state_q == S_IDLE) && !flush_req_i && !empty;

`ifdef BPU_UPD_COALESCE_EN
  logic [QW-1:0] tail_idx;
  assign tail_idx = QW'(wptr_q - 1'b1);
  // The tail is only mergeable if this cycle's drain is not taking it away.
  assign tail_hit = (state_q == S_IDLE) && !empty && (mem_pc[tail_idx] == upd_pc_i)
                    && !(pop && (occ == PW'(1)));
`else
  assign tail_hit = 1'b0;
`endif

  assign upd_ready_o       = (state_q == S_FLUSH) || !full || tail_hit;
  assign accept            = upd_valid_i && upd_ready_o;
  assign coalesce          = accept && tail_hit && !flush_req_i;
  assign push              = accept && !coalesce && (state_q == S_IDLE) && !flush_req_i;
  assign flush_busy_o      = (state_q == S_FLUSH);
  assign predict_disable_o = (state_q == S_FLUSH);

  always_comb begin
    state_d      = state_q;
    walk_d       = walk_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    wr_en_d      = 1'b0;
    wr_inv_d     = 1'b0;
    wr_index_d   = wr_index_o;
    wr_tag_d     = wr_tag_o;
    wr_target_d  = wr_target_o;
    wr_jump_d    = wr_jump_o;
    flush_done_d = 1'b0;
    drop_inc     = '0;
    case (state_q)
      S_FLUSH: begin
        drop_inc = PW'(accept);
        if (flush_req_i || (walk_q != WALK_END)) begin
          wr_en_d    = 1'b1;
          wr_inv_d   = 1'b1;
          wr_index_d = flush_req_i ? '0 : walk_q[IW-1:0];
          walk_d     = flush_req_i ? WW'(1) : walk_q + 1'b1;
        end else begin
          state_d      = S_IDLE;
          walk_d       = '0;
          flush_done_d = 1'b1;
        end
      end
      default: begin
        if (flush_req_i) begin
          // Whatever is queued belongs to the old table contents and is thrown away.
          state_d  = S_FLUSH;
          walk_d   = '0;
          rptr_d   = wptr_q;
          drop_inc = occ + PW'(accept);
        end else begin
          if (pop) begin
            rptr_d      = rptr_q + 1'b1;
            wr_en_d     = 1'b1;
            wr_index_d  = head_pc[IW+1:2];
            wr_tag_d    = head_pc[ADDR_WIDTH-1:IW+2];
            wr_target_d = mem_tgt[rptr_q[QW-1:0]];
            wr_jump_d   = mem_jmp[rptr_q[QW-1:0]];
          end
          if (push) wptr_d = wptr_q + 1'b1;
        end
      end
    endcase
    drop_sum  = SW'(dropped_cnt_o) + SW'(drop_inc);
    dropped_d = drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_FLUSH;
      walk_q          <= '0;
      wptr_q          <= '0;
      rptr_q          <= '0;
      wr_en_o         <= 1'b0;
      wr_invalidate_o <= 1'b0;
      wr_index_o      <= '0;
      wr_tag_o        <= '0;
      wr_target_o     <= '0;
      wr_jump_o       <= 1'b0;
      flush_done_o    <= 1'b0;
      dropped_cnt_o   <= '0;
    end else begin
      state_q         <= state_d;
      walk_q          <= walk_d;
      wptr_q          <= wptr_d;
      rptr_q          <= rptr_d;
      wr_en_o         <= wr_en_d;
      wr_invalidate_o <= wr_inv_d;
      wr_index_o      <= wr_index_d;
      wr_tag_o        <= wr_tag_d;
      wr_target_o     <= wr_target_d;
      wr_jump_o       <= wr_jump_d;
      flush_done_o    <= flush_done_d;
      dropped_cnt_o   <= dropped_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wptr_q[QW-1:0]]  <= upd_pc_i;
      mem_tgt[wptr_q[QW-1:0]] <= upd_target_i;
      mem_jmp[wptr_q[QW-1:0]] <= upd_jump_i;
    end
`ifdef BPU_UPD_COALESCE_EN
    else if (coalesce) begin
      mem_tgt[tail_idx] <= upd_target_i;
      mem_jmp[tail_idx] <= upd_jump_i;
    end
`endif
  end
endmodule
